// File: rtl/xor_parity_rx_if.sv
// Serial-side and status bundle for the XOR parity receiver.
// master: whoever drives the line and reads status; slave: the receiver itself.
interface xor_parity_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              din;
  logic              din_valid;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
  logic [7:0]        err_cnt;

  modport master (
    output din, din_valid, err_clr,
    input  data_out, done, parity_err, frame_err, busy, err_cnt
  );

  modport slave (
    input  din, din_valid, err_clr,
    output data_out, done, parity_err, frame_err, busy, err_cnt
  );
endinterface

// File: rtl/xor_parity_rx.sv
// XOR-parity frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Reports parity/framing errors per frame and keeps a saturating error count.
module xor_parity_rx #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  xor_parity_rx_if.slave bus
);

  localparam int unsigned          CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic              frame_end;

  logic [DATA_W-1:0] shreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc_q;
  logic              p_bad_q;

  logic [DATA_W-1:0] data_q;
  logic              done_q;
  logic              perr_q;
  logic              ferr_q;
  logic [7:0]        err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Every transition is gated by din_valid; the STOP exit is the frame-complete event.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        IDLE:    if (!bus.din) state_d = DATA;
        DATA:    if (cnt_q == CNT_LAST) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      p_bad_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      done_q <= frame_end;

      if (bus.din_valid) begin
        case (state_q)
          IDLE: begin
            if (!bus.din) begin
              acc_q <= 1'b0;
              cnt_q <= '0;
            end
          end
          DATA: begin
            shreg_q <= {bus.din, shreg_q[DATA_W-1:1]};
            acc_q   <= acc_q ^ bus.din;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
          PARITY: p_bad_q <= acc_q ^ bus.din ^ ODD;
          STOP: begin
            data_q <= shreg_q;
            perr_q <= p_bad_q;
            ferr_q <= ~bus.din;
          end
          default: ;
        endcase
      end

      // Clear beats a coincident increment.
      if (bus.err_clr)
        err_cnt_q <= '0;
      else if (frame_end && (p_bad_q || !bus.din) && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.done       = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_xor_parity_rx.sv
// Directed bench for xor_parity_rx (DATA_W=8, even parity).
module tb_xor_parity_rx;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   base;

  xor_parity_rx_if #(.DATA_W(8)) bus ();

  xor_parity_rx #(.DATA_W(8), .ODD(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // done lasts one cycle, so exactly one falling edge sees each pulse.
  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int unsigned gap);
    for (int unsigned i = 0; i < gap; i++) begin
      bus.din_valid = 1'b0;
      bus.din       = i[0];
      @(posedge clk); #1;
    end
    bus.din       = b;
    bus.din_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int unsigned gap, input logic clr);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    bus.err_clr = clr;
    send_bit(stp, gap);
    bus.err_clr = 1'b0;
  endtask

  task automatic drop();
    bus.din_valid = 1'b0;
    bus.din       = 1'b1;
  endtask

  task automatic idle_cycle();
    drop();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] d;
    rst           = 1'b1;
    bus.din       = 1'b1;
    bus.din_valid = 1'b0;
    bus.err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_data",  bus.data_out,   0);
    check("rst_done",  bus.done,       0);
    check("rst_perr",  bus.parity_err, 0);
    check("rst_ferr",  bus.frame_err,  0);
    check("rst_busy",  bus.busy,       0);
    check("rst_errc",  bus.err_cnt,    0);

    // 1: clean 0xA5, watching busy across the frame
    d = 8'hA5;
    send_bit(1'b0, 0);
    check("t1_busy_start", bus.busy, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i], 0);
    send_bit(1'b0, 0);
    check("t1_busy_par", bus.busy, 1);
    check("t1_nodone_early", bus.done, 0);
    send_bit(1'b1, 0);
    drop();
    check("t1_done",  bus.done,       1);
    check("t1_data",  bus.data_out,   8'hA5);
    check("t1_perr",  bus.parity_err, 0);
    check("t1_ferr",  bus.frame_err,  0);
    check("t1_errc",  bus.err_cnt,    0);
    check("t1_busy_end", bus.busy,    0);
    idle_cycle();
    check("t1_done_1cyc", bus.done, 0);
    check("t1_perr_held", bus.parity_err, 0);

    // 2: parity error, then clean 0x3C
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0);
    drop();
    check("t2_data", bus.data_out,   8'hA5);
    check("t2_perr", bus.parity_err, 1);
    check("t2_ferr", bus.frame_err,  0);
    check("t2_errc", bus.err_cnt,    1);
    idle_cycle();
    check("t2_perr_held", bus.parity_err, 1);
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    drop();
    check("t2b_data", bus.data_out,   8'h3C);
    check("t2b_perr", bus.parity_err, 0);
    check("t2b_errc", bus.err_cnt,    1);
    idle_cycle();

    // 3: framing error with 3 stalled cycles around every bit
    base = done_cnt;
    send_frame(8'h0F, 1'b0, 1'b0, 3, 1'b0);
    drop();
    check("t3_done", bus.done,       1);
    check("t3_data", bus.data_out,   8'h0F);
    check("t3_ferr", bus.frame_err,  1);
    check("t3_perr", bus.parity_err, 0);
    check("t3_errc", bus.err_cnt,    2);
    repeat (3) idle_cycle();
    check("t3_pulses", done_cnt - base, 1);

    // 4: idle ones then two back-to-back frames
    base = done_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    check("t4_idle_busy", bus.busy, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0, 1'b0);
    check("t4a_done", bus.done,     1);
    check("t4a_data", bus.data_out, 8'hFF);
    check("t4a_perr", bus.parity_err, 0);
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    drop();
    check("t4b_done", bus.done,     1);
    check("t4b_data", bus.data_out, 8'h01);
    check("t4b_perr", bus.parity_err, 0);
    check("t4b_ferr", bus.frame_err,  0);
    check("t4_errc",  bus.err_cnt,    2);
    idle_cycle();
    check("t4_pulses", done_cnt - base, 2);

    // 5: reset after 4 data bits, trailing ones, then clean 0x5A
    base = done_cnt;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    drop();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_data", bus.data_out,   0);
    check("t5_done", bus.done,       0);
    check("t5_perr", bus.parity_err, 0);
    check("t5_ferr", bus.frame_err,  0);
    check("t5_busy", bus.busy,       0);
    check("t5_errc", bus.err_cnt,    0);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 0);
    idle_cycle();
    check("t5_no_pulse", done_cnt - base, 0);
    check("t5_idle_busy", bus.busy, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
    drop();
    check("t5_rx_data", bus.data_out,   8'h5A);
    check("t5_rx_perr", bus.parity_err, 0);
    check("t5_rx_ferr", bus.frame_err,  0);
    idle_cycle();

    // 6: saturation then clear coinciding with a bad frame's done
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
      if (i == 253) check("t6_errc_254", bus.err_cnt, 254);
      if (i == 254) check("t6_errc_255", bus.err_cnt, 255);
    end
    drop();
    check("t6_errc_sat", bus.err_cnt,    255);
    check("t6_perr",     bus.parity_err, 1);
    idle_cycle();
    send_frame(8'h00, 1'b1, 1'b1, 0, 1'b1);
    drop();
    check("t6_clr_done", bus.done,       1);
    check("t6_clr_perr", bus.parity_err, 1);
    check("t6_clr_errc", bus.err_cnt,    0);
    idle_cycle();
    send_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
    drop();
    check("t6_after_clr", bus.err_cnt, 1);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
Serial receiver and checker for XOR-parity-protected frames. It is the receiving end of the team's XOR parity generator/serializer. Frame format, one bit per valid-qualified sample: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1). The block deserializes each frame, recomputes the XOR parity, flags parity and framing errors, and keeps a saturating error count for the bench and for status logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 2..16).
ODD, 0, parity sense: 0 = even (data plus parity has an even number of ones), 1 = odd.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
din  input  1  serial data bit.
din_valid  input  1  din is sampled only on cycles where din_valid=1.
err_clr  input  1  synchronous clear of err_cnt.
data_out  output  DATA_W  last received data word.
done  output  1  one-cycle pulse when a frame completes.
parity_err  output  1  parity result for the last frame; valid with done, held until the next done.
frame_err  output  1  stop bit was 0 in the last frame; valid with done, held until the next done.
busy  output  1  high whenever state is not IDLE.
err_cnt  output  8  saturating count of frames with parity_err or frame_err set.

Behaviour:
- Reset (rst=1 at a clk edge) sets all outputs to 0 (data_out, done, parity_err, frame_err, busy, err_cnt); state to IDLE; clears shift register, bit counter and parity accumulator. Reset takes priority over every other input.
- States: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with din_valid=1. When din_valid=0, the state, counters and accumulator hold and done stays 0.
- IDLE: din_valid=1 and din=0 -> clear acc and bit counter, go to DATA. din_valid=1 and din=1 is line idle: ignore, stay in IDLE.
- DATA: each valid bit enters the shift register at the MSB end and the register shifts right, so the first bit received ends up at bit 0. Each bit also updates acc <= acc ^ din and increments the bit counter. After the DATA_W-th bit -> PARITY.
- PARITY: p_bad = acc ^ din ^ ODD; latch it internally -> STOP.
- STOP: on the valid bit, on the same edge:
  - data_out <= shift register;
  - parity_err <= p_bad;
  - frame_err <= ~din;
  - done <= 1;
  - go to IDLE.
- Latency: done is high in the cycle after the edge that samples the stop bit, and for exactly one cycle.
- A frame that completes while in error is still delivered: data_out is updated regardless of errors.
- err_cnt:
  - increments by 1 on the edge that asserts done, if (p_bad | ~din);
  - saturates at 255, with no wrap;
  - if err_clr is high on the same edge as an increment, the clear wins and err_cnt = 0;
  - err_clr does not affect any other state.
- Back-to-back frames: a start bit may arrive on the very next valid cycle after the stop bit. The IDLE check happens while done is high and is not blocked by it.
- Reset mid-frame aborts the frame: no done pulse, the partial word is discarded, and data_out and the error flags return to 0.
- busy = (state != IDLE), registered with the state.

Test Plan:
1. Clean frame, DATA_W=8, even parity. Drive, one bit per cycle with din_valid=1: start 0, data 0xA5 LSB first (1,0,1,0,0,1,0,1), parity 0, stop 1. Required: data_out=0xA5, done high one cycle after the stop-bit sample, parity_err=0, frame_err=0, err_cnt=0. busy is high from the cycle after the start bit until the cycle after stop.
2. Parity error. Same frame with parity bit 1. Required: data_out=0xA5, parity_err=1, frame_err=0, err_cnt=1. Then send a clean 0x3C frame (parity 0). Required: parity_err=0, err_cnt stays 1.
3. Framing error and stalls. Send 0x0F with parity 0, stop bit 0, with din_valid deasserted for 3 cycles between every bit. Required: data_out=0x0F, frame_err=1, parity_err=0, exactly one done pulse, err_cnt increments. din changes while din_valid=0 must have no effect.
4. Idle and back-to-back. Drive 5 idle 1s, then two frames with no gap (0xFF parity 0, then 0x01 parity 1). Required: two done pulses; data_out=0xFF and then 0x01; no errors.
5. Reset mid-frame. Pulse rst after 4 data bits of a frame. Required:
   - all outputs are 0 the cycle after reset;
   - no done pulse;
   - the remaining bits of the aborted frame (trailing 1s) do not create a frame;
   - a following clean 0x5A frame is received correctly.
6. Saturation and clear. Send 260 parity-error frames. Required: err_cnt reads 255 and holds there. Then assert err_clr on the same edge as a done for a bad frame. Required: err_cnt=0.
